// File: rtl/hello_world_key_debounce_pkg.sv
// Shared constants for the key conditioning stage: idle level, default
// debounce length and synchroniser depth.
package hello_world_key_debounce_pkg;

    // Keys are active-low, so the released/idle level is 1.
    localparam logic KEY_IDLE = 1'b1;

    // 20 ms at 50 MHz.
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;

    // Two flops between the pad and any logic.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/hello_world_debounce_bit.sv
// Single key bit: two-flop synchroniser, stability counter, debounced level
// register and one-cycle press/release strobes. All outputs are registered.
module hello_world_debounce_bit
    import hello_world_key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_key_raw,
    output logic o_key_clean,
    output logic o_press,
    output logic o_release
);

    // Terminal count: the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_clean;
    logic                   r_press;
    logic                   r_release;

    logic                   w_sync_out;
    logic                   w_mismatch;
    logic                   w_accept;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_mismatch = w_sync_out ^ r_clean;
    assign w_accept   = w_mismatch && (r_cnt == CNT_MAX);

    // Plain shift chain into the clock domain; idles at the released level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{KEY_IDLE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_key_raw};
        end
    end

    // Count consecutive cycles the synchronised level differs from the
    // accepted one; any agreement restarts qualification. Counter clears on
    // acceptance, so it never exceeds CNT_MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!w_mismatch || w_accept) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Accept the new level and strobe the matching edge for exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clean   <= KEY_IDLE;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else if (w_accept) begin
            r_clean   <= w_sync_out;
            r_press   <= (w_sync_out == ~KEY_IDLE);
            r_release <= (w_sync_out == KEY_IDLE);
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end
    end

    assign o_key_clean = r_clean;
    assign o_press     = r_press;
    assign o_release   = r_release;

endmodule

// File: rtl/hello_world_key_debounce.sv
// Key conditioning in front of the key PIO: per-bit synchronise + debounce,
// clean active-low levels for in_port and press/release strobes for hardware
// consumers. Bits are fully independent.
module hello_world_key_debounce
    import hello_world_key_debounce_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_clean,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    // Derived; wide enough to hold DEBOUNCE_CYCLES-1.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] w_clean;
    logic [WIDTH-1:0] w_press;
    logic [WIDTH-1:0] w_release;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        hello_world_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk         (clk),
            .reset       (reset),
            .i_key_raw   (key_raw[g]),
            .o_key_clean (w_clean[g]),
            .o_press     (w_press[g]),
            .o_release   (w_release[g])
        );
    end

    assign key_clean     = w_clean;
    assign press_pulse   = w_press;
    assign release_pulse = w_release;

endmodule

// File: tb/tb_hello_world_key_debounce.sv
// Scoreboard bench: a window-based reference model pushes the expected
// outputs after every clock edge; an independent monitor pops and compares.
module tb_hello_world_key_debounce;

    localparam int W = 2;
    localparam int D = 4;

    typedef struct packed {
        logic [W-1:0] clean;
        logic [W-1:0] press;
        logic [W-1:0] rel;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [W-1:0] key_raw;
    logic [W-1:0] key_clean;
    logic [W-1:0] press_pulse;
    logic [W-1:0] release_pulse;
    logic         clk_en;

    int total = 0;
    int bad   = 0;

    exp_t         exp_q[$];
    logic [W-1:0] hist[$];   // raw samples taken at each edge since reset

    hello_world_key_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_raw       (key_raw),
        .key_clean     (key_clean),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    // Reference: a bit flips when the raw samples from two edges ago and the
    // D-1 edges before that all disagree with the current clean level.
    // Samples older than the last reset count as released (1).
    initial begin : model
        logic [W-1:0] m_clean;
        exp_t e;
        m_clean = '1;
        forever begin
            @(posedge clk);
            e = '0;
            if (reset) begin
                hist.delete();
                m_clean = '1;
            end else begin
                for (int b = 0; b < W; b++) begin
                    bit all_diff;
                    all_diff = 1'b1;
                    for (int k = 0; k < D; k++) begin
                        int idx;
                        logic s;
                        idx = hist.size() - 2 - k;
                        s = (idx < 0) ? 1'b1 : hist[idx][b];
                        if (s == m_clean[b]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        m_clean[b] = ~m_clean[b];
                        if (m_clean[b] == 1'b0) e.press[b] = 1'b1;
                        else                    e.rel[b]   = 1'b1;
                    end
                end
                hist.push_back(key_raw);
                if (hist.size() > 32) void'(hist.pop_front());
            end
            e.clean = m_clean;
            exp_q.push_back(e);
        end
    end

    // Monitor: one expected entry per edge, compared away from the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (key_clean !== e.clean || press_pulse !== e.press || release_pulse !== e.rel) begin
                    bad++;
                    $display("FAIL outputs at %0t: got clean=%b press=%b rel=%b want clean=%b press=%b rel=%b",
                             $time, key_clean, press_pulse, release_pulse, e.clean, e.press, e.rel);
                end
            end
        end
    end

    task automatic drive(input logic [W-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            key_raw = v;
        end
    endtask

    task automatic check_now(input string name, input logic [3*W-1:0] got, input logic [3*W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // Apply v, then count edges until the chosen strobe appears (bounded).
    task automatic latency(input string name, input logic [W-1:0] v, input logic [W-1:0] mask,
                           input bit is_press, input int want);
        int k;
        bit seen;
        @(negedge clk);
        key_raw = v;
        k = 0;
        seen = 0;
        while (!seen && k < 30) begin
            @(negedge clk);
            k++;
            if (((is_press ? press_pulse : release_pulse) & mask) != 0) seen = 1;
        end
        total++;
        if (!seen || k != want) begin
            bad++;
            $display("FAIL %s: edges=%0d seen=%0d want %0d", name, k, seen, want);
        end
    endtask

    initial begin
        clk_en  = 1'b0;
        key_raw = '1;
        reset   = 1'b0;
        #1 reset = 1'b1;
        #1 check_now("reset_no_clock", {key_clean, press_pulse, release_pulse}, {2'b11, 2'b00, 2'b00});
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        drive(2'b11, 20);

        // Clean press then release on bit 0.
        latency("press_latency", 2'b10, 2'b01, 1'b1, D + 2);
        drive(2'b10, 5);
        latency("release_latency", 2'b11, 2'b01, 1'b0, D + 2);
        drive(2'b11, 5);

        // Bounce then settle low; then a short glitch.
        drive(2'b10, 1); drive(2'b11, 1); drive(2'b10, 2); drive(2'b11, 1);
        drive(2'b10, 12);
        drive(2'b11, 12);
        drive(2'b10, 3);
        drive(2'b11, 10);

        // Both bits together, then release only bit 0.
        drive(2'b00, 10);
        drive(2'b01, 10);
        drive(2'b11, 10);

        // Reset mid-count with bit 1 held low.
        drive(2'b01, 5);
        #1 reset = 1'b1;
        #1 check_now("reset_mid_count", {key_clean, press_pulse, release_pulse}, {2'b11, 2'b00, 2'b00});
        @(negedge clk);
        #1 reset = 1'b0;
        drive(2'b01, 12);
        drive(2'b11, 10);

        // Long hold.
        drive(2'b10, 1000);
        drive(2'b11, 10);

        // Random bouncing with biased hold lengths and occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] v;
            v = W'($urandom);
            drive(v, $urandom_range(1, 8));
            if ($urandom_range(0, 60) == 0) begin
                @(negedge clk);
                #1 reset = 1'b1;
                @(negedge clk);
                #1 reset = 1'b0;
            end
        end
        drive(2'b11, 10);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
